mem_responder: RTL and testbench

Word-addressed synchronous memory that answers the datapath's memory requests. It samples `Read`/`Write` together with the MAR and MDR contents. After a programmable number of wait states it returns read data on `Mdatain`, the same bus that feeds the MDR. Completion is signalled with a four-phase request/done handshake. This block is the responder end of the MDR/MAR memory interface.

---
 rtl/mem_responder.sv | 126 ++++++++++++
 tb/tb_mem_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-addressed 32-bit memory on the MAR/MDR interface.
// A request is captured in IDLE. It waits WAIT_CYCLES extra cycles and is then
// performed, after which MemDone is held until both Read and Write drop.
// Rejected requests (out-of-range address or Read+Write together) follow the
// same timing. They leave the memory and Mdatain untouched and raise AddrErr in DONE.
module mem_responder #(
    parameter int ADDR_BITS   = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        Read,
    input  logic        Write,
    input  logic [31:0] MAR_addr,
    input  logic [31:0] MDR_data,
    output logic [31:0] Mdatain,
    output logic        MemDone,
    output logic        Busy,
    output logic        AddrErr
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [31:0]            data_q, data_d;
    logic [31:0]            mdatain_q, mdatain_d;
    logic                   is_write_q, is_write_d;
    logic                   err_q, err_d;
    logic                   mem_we;
    logic                   req_bad;

    logic [31:0] mem [DEPTH];

    // Only the in-range low bits are kept.
    // A nonzero upper part is folded into err at capture time.
    assign req_bad = ((MAR_addr >> ADDR_BITS) != 32'd0) || (Read && Write);

    // Next-state, capture and access logic for the IDLE/WAIT/DONE handshake
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        mdatain_d  = mdatain_q;
        is_write_d = is_write_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Read || Write) begin
                    state_d    = S_WAIT;
                    addr_d     = MAR_addr[ADDR_BITS-1:0];
                    data_d     = MDR_data;
                    is_write_d = Write;
                    err_d      = req_bad;
                    cnt_d      = 4'(WAIT_CYCLES);
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    if (!err_q) begin
                        if (is_write_q) begin
                            mem_we = 1'b1;
                        end else begin
                            mdatain_d = mem[addr_q];
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                if (!Read && !Write) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and data registers; clear aborts any access in flight
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            data_q     <= 32'd0;
            mdatain_q  <= 32'd0;
            is_write_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            mdatain_q  <= mdatain_d;
            is_write_q <= is_write_d;
            err_q      <= err_d;
        end
    end

    // Memory array is never cleared.
    // The write is suppressed when clear lands on the commit edge.
    always_ff @(posedge clock) begin
        if (mem_we && !clear) begin
            mem[addr_q] <= data_q;
        end
    end

    assign Mdatain = mdatain_q;
    assign MemDone = (state_q == S_DONE);
    assign Busy    = (state_q != S_IDLE);
    assign AddrErr = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder.
// It exercises a default instance (WAIT_CYCLES=2) and a zero-wait instance (WAIT_CYCLES=0).
module tb_mem_responder;

    localparam int NVEC = 13;

    typedef struct {
        bit          sel;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_err;
        logic [31:0] exp_data;
        int          hold;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        clear;
    logic        rd_a, wr_a, rd_b, wr_b;
    logic [31:0] addr_a, data_a, addr_b, data_b;
    logic [31:0] md_a, md_b;
    logic        done_a, busy_a, err_a, done_b, busy_b, err_b;

    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t sbq[$];
    vec_t vecs[NVEC];

    always #5 clock = ~clock;

    mem_responder dut (
        .clock(clock), .clear(clear), .Read(rd_a), .Write(wr_a),
        .MAR_addr(addr_a), .MDR_data(data_a), .Mdatain(md_a),
        .MemDone(done_a), .Busy(busy_a), .AddrErr(err_a)
    );

    mem_responder #(.ADDR_BITS(9), .WAIT_CYCLES(0)) dut0 (
        .clock(clock), .clear(clear), .Read(rd_b), .Write(wr_b),
        .MAR_addr(addr_b), .MDR_data(data_b), .Mdatain(md_b),
        .MemDone(done_b), .Busy(busy_b), .AddrErr(err_b)
    );

    function automatic logic [31:0] md_of(bit sel);
        return sel ? md_b : md_a;
    endfunction
    function automatic logic done_of(bit sel);
        return sel ? done_b : done_a;
    endfunction
    function automatic logic busy_of(bit sel);
        return sel ? busy_b : busy_a;
    endfunction
    function automatic logic err_of(bit sel);
        return sel ? err_b : err_a;
    endfunction

    // Compare one value and log a failure line if it differs
    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive the request lines of the selected instance
    task automatic drive_req(input bit sel, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            rd_b = rd; wr_b = wr; addr_b = a; data_b = d;
        end else begin
            rd_a = rd; wr_a = wr; addr_a = a; data_a = d;
        end
    endtask

    // Drive a request and push the expected completion onto the scoreboard
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        drive_req(v.sel, v.rd, v.wr, v.addr, v.data);
        e.err  = v.exp_err;
        e.data = v.exp_data;
        sbq.push_back(e);
    endtask

    // Follow one access from capture to return-to-IDLE, popping its expectation at MemDone
    task automatic checkOutput(input bit sel, input int hold);
        exp_t        e;
        int          cycles;
        int          wait_cycles;
        logic [31:0] a;
        wait_cycles = sel ? 0 : 2;
        @(posedge clock);
        @(negedge clock);
        check_val("busy_after_capture", busy_of(sel), 1'b1);
        check_val("memdone_low_in_wait", done_of(sel), 1'b0);
        cycles = 0;
        while (!done_of(sel) && cycles < 40) begin
            @(posedge clock);
            @(negedge clock);
            cycles++;
        end
        check_val("latency_edges", cycles, wait_cycles + 1);
        e.err  = 1'bx;
        e.data = 'x;
        if (sbq.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL scoreboard_empty: got no entry, expected one");
        end else begin
            e = sbq.pop_front();
        end
        check_val("addrerr", err_of(sel), e.err);
        check_val("mdatain", md_of(sel), e.data);
        a = sel ? addr_b : addr_a;
        for (int i = 0; i < hold; i++) begin
            a = a + 32'd3;
            if (sel) addr_b = a; else addr_a = a;
            @(negedge clock);
            check_val("memdone_held", done_of(sel), 1'b1);
            check_val("busy_held", busy_of(sel), 1'b1);
            check_val("mdatain_held", md_of(sel), e.data);
        end
        drive_req(sel, 1'b0, 1'b0, a, 32'd0);
        @(negedge clock);
        check_val("memdone_fall", done_of(sel), 1'b0);
        check_val("busy_fall", busy_of(sel), 1'b0);
        check_val("addrerr_fall", err_of(sel), 1'b0);
        @(negedge clock);
        check_val("no_second_access", busy_of(sel), 1'b0);
    endtask

    // Watchdog so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, vector table, mid-access reset, zero-wait checks
    initial begin
        vec_t v;
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0012, 32'h0000_0000, 1'b0, 32'h0000_0000, 0};
        vecs[0].rd = 1'b0; vecs[0].wr = 1'b1; vecs[0].data = 32'h0000_00A5;
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0012, 32'h0000_0000, 1'b0, 32'h0000_00A5, 5};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0000, 1'b1, 32'h0000_00A5, 0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0012, 32'hFFFF_FFFF, 1'b1, 32'h0000_00A5, 0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0012, 32'h0000_0000, 1'b0, 32'h0000_00A5, 0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0034, 32'h1234_5678, 1'b0, 32'h0000_00A5, 0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0034, 32'h0000_0000, 1'b0, 32'h1234_5678, 0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h0000_01FF, 32'hCAFE_F00D, 1'b0, 32'h1234_5678, 0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0000_01FF, 32'h0000_0000, 1'b0, 32'hCAFE_F00D, 0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hCAFE_F00D, 0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h0000_0012, 32'h0000_A5A5, 1'b0, 32'h0000_0000, 0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h0000_0012, 32'h0000_0000, 1'b0, 32'h0000_A5A5, 3};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0000, 1'b1, 32'h0000_A5A5, 0};

        clear = 1'b1;
        rd_b = 1'b0; wr_b = 1'b0; addr_b = 32'd0; data_b = 32'd0;
        v = '{1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0000_0000, 1'b1, 32'h0000_0000, 0};
        applyStimulus(v);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_val("reset_mdatain", md_a, 32'd0);
        check_val("reset_memdone", done_a, 1'b0);
        check_val("reset_busy", busy_a, 1'b0);
        check_val("reset_addrerr", err_a, 1'b0);
        check_val("reset_busy_zero_wait", busy_b, 1'b0);
        clear = 1'b0;
        checkOutput(1'b0, 0);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i].sel, vecs[i].hold);
        end

        drive_req(1'b0, 1'b0, 1'b1, 32'h0000_0012, 32'hDEAD_BEEF);
        @(posedge clock);
        @(negedge clock);
        check_val("midwrite_busy", busy_a, 1'b1);
        clear = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_val("midwrite_reset_busy", busy_a, 1'b0);
        check_val("midwrite_reset_memdone", done_a, 1'b0);
        check_val("midwrite_reset_mdatain", md_a, 32'd0);
        check_val("midwrite_reset_addrerr", err_a, 1'b0);
        clear = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clock);
        check_val("midwrite_idle_after_release", busy_a, 1'b0);

        v = '{1'b0, 1'b1, 1'b0, 32'h0000_0012, 32'h0000_0000, 1'b0, 32'h0000_00A5, 0};
        applyStimulus(v);
        checkOutput(1'b0, 0);
        v = '{1'b1, 1'b1, 1'b0, 32'h0000_0012, 32'h0000_0000, 1'b0, 32'h0000_A5A5, 2};
        applyStimulus(v);
        checkOutput(1'b1, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
